ipbb_sfw_pkt_fifo: RTL and testbench
====================================

IPBB_SFW_PKT_FIFO -- requirements
Module: ipbb_sfw_pkt_fifo

Interface
REQ-001 SHALL have parameter DW, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, word capacity; power of two, at least 4.
REQ-003 SHALL have ports: clk  in  1  sole clock, all logic rising-edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports: push  in  1  write din this cycle.
REQ-006 SHALL have ports: din  in  DW  write data.
REQ-007 SHALL have ports: push_eop  in  1  pushed word is last of packet.
REQ-008 SHALL have ports: push_err  in  1  qualifies push_eop; packet is bad, drop it.
REQ-009 SHALL have ports: pop  in  1  read one committed word.
REQ-010 SHALL have ports: dout  out  DW, dout_eop  out  1, dout_vld  out  1  read data, its eop flag, and valid.
REQ-011 SHALL have ports: full  out  1, empty  out  1  status.
REQ-012 SHALL have ports: used  out  $clog2(DEPTH)+1  occupancy, committed plus uncommitted words.
REQ-013 SHALL have ports: pkt_cnt  out  $clog2(DEPTH)+1  committed packets not yet fully popped.
REQ-014 SHALL have ports: overflow, underflow, drop  out  1 each  single-cycle event pulses.
REQ-015 SHALL have ports: drop_cnt  out  16  saturating count of dropped packets.

Function
REQ-016 SHALL store {din, push_eop} per word; pointers are $clog2(DEPTH)+1 bits with a wrap bit, so all DEPTH words are usable.
REQ-017 SHALL track wptr, rptr and cptr (commit pointer); full = (used == DEPTH); empty = (rptr == cptr).
REQ-018 SHALL on push & push_eop & !push_err with a non-truncated packet set cptr to wptr+1 on the next edge; the read side sees the packet 1 cycle after that push.
REQ-019 SHALL on push & push_eop & push_err rewind wptr to cptr, discard the packet, and pulse drop.
REQ-020 SHALL, on push while full, discard the word, pulse overflow, and enter S_TRUNC; S_TRUNC discards all further words; the eop push rewinds wptr to cptr and pulses drop, whether the eop word is stored or discarded.
REQ-021 SHALL implement write FSM states S_IDLE (between packets), S_PKT (packet open), S_TRUNC (packet doomed).
REQ-022 SHALL use these FSM transitions: push non-eop: IDLE->PKT; eop push: ->IDLE; push while full: ->TRUNC.
REQ-023 SHALL, on pop while !empty, read the RAM; dout, dout_eop and dout_vld=1 appear 1 cycle later; dout_vld is 0 otherwise.
REQ-024 SHALL, on pop while empty, leave rptr unchanged, hold dout_vld 0, and pulse underflow.
REQ-025 SHALL increment pkt_cnt at commit and decrement it when an eop word is popped; simultaneous increment and decrement leave it unchanged.
REQ-026 SHALL allow push, commit, pop and rewind in the same cycle; rewind never moves wptr behind rptr, because rptr never passes cptr.
REQ-027 SHALL have all status outputs registered; used reflects pushes and pops 1 cycle after the edge.

Reset
REQ-028 SHALL, while rst_n=0, immediately clear pointers, pkt_cnt, used, drop_cnt, dout_vld, overflow, underflow and drop, and set FSM=S_IDLE, empty=1, full=0, dout=0, dout_eop=0.
REQ-029 SHALL discard committed and uncommitted data on reset mid-packet, with no drop pulse; RAM contents are not reset.

Configuration
REQ-030 SHALL, with IPBB_SFW_DROP_CNT_EN defined, increment drop_cnt on every drop pulse, saturating at 16'hFFFF.
REQ-031 SHALL, without IPBB_SFW_DROP_CNT_EN, tie drop_cnt to 0 and synthesise no counter; the drop pulse remains.

Structure
REQ-032 SHALL take the FSM state enum (S_IDLE/S_PKT/S_TRUNC) and the pointer-width helper function from the shared package ipbb_sfw_pkg.
REQ-033 SHALL place storage in sub-module ipbb_sfw_sdp_ram, a simple dual-port RAM of width DW+1 and depth DEPTH with 1-cycle registered read.

Verification (DW=8, DEPTH=16)
REQ-034 SHALL cover: push 4 words 0x10..0x13, eop on last -> empty falls 1 cycle after eop push; 4 pops return 0x10..0x13, dout_eop on 0x13; pkt_cnt 1->0.
REQ-035 SHALL cover: push 3 words, eop with push_err -> drop pulse, used returns to 0, empty stays 1, drop_cnt=1 when macro defined, else 0.
REQ-036 SHALL cover: commit 10-word packet, then push 8-word packet -> 7th word gives overflow, FSM=S_TRUNC; at eop drop pulse, used=10, first packet pops intact.
REQ-037 SHALL cover: pop when empty -> underflow pulse, dout_vld=0, rptr unchanged.
REQ-038 SHALL cover: stream 1000 random packets of 1..12 words with concurrent pops across many wraps -> output equals the good-packet scoreboard, pkt_cnt never negative.
REQ-039 SHALL cover: assert rst_n=0 mid-packet with 1 committed packet -> empty=1, used=0, pkt_cnt=0 immediately; a new packet after release pops correctly.

Source files
------------

// File: rtl/ipbb_sfw_pkg.sv
// rtl/ipbb_sfw_pkg.sv - shared write-FSM state type and pointer sizing for the store-and-forward packet FIFO
package ipbb_sfw_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PKT   = 2'd1,
        S_TRUNC = 2'd2
    } wr_state_e;

    // One extra wrap bit lets full and empty be told apart with all DEPTH words in use.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ipbb_sfw_sdp_ram.sv
// rtl/ipbb_sfw_sdp_ram.sv - simple dual-port RAM, one write port and one read port with registered read data
module ipbb_sfw_sdp_ram #(
    parameter int W     = 9,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rdata_d;
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Only the read register is reset so the output is clean; the array keeps its contents.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ipbb_sfw_pkt_fifo.sv
// rtl/ipbb_sfw_pkt_fifo.sv - store-and-forward packet FIFO that only releases fully received, error-free packets
// Optional dropped-packet counter enabled by defining IPBB_SFW_DROP_CNT_EN.
module ipbb_sfw_pkt_fifo
    import ipbb_sfw_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [DW-1:0]          din,
    input  logic                   push_eop,
    input  logic                   push_err,
    input  logic                   pop,
    output logic [DW-1:0]          dout,
    output logic                   dout_eop,
    output logic                   dout_vld,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] used,
    output logic [$clog2(DEPTH):0] pkt_cnt,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   drop,
    output logic [15:0]            drop_cnt
);

    localparam int PW = ptr_width(DEPTH);
    localparam int AW = PW - 1;

    wr_state_e state_q, state_d;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] cptr_q, cptr_d;
    logic [PW-1:0] used_q, used_d;
    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          dout_vld_q, dout_vld_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          drop_q, drop_d;

    logic          wr_en;
    logic          rd_en;
    logic          commit;
    logic          rewind;
    logic          eop_popped;
    logic [DW:0]   rd_word;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_PKT: begin
                if (push) begin
                    if (push_eop) begin
                        state_d = S_IDLE;
                    end else if (full_q) begin
                        state_d = S_TRUNC;
                    end else begin
                        state_d = S_PKT;
                    end
                end
            end
            S_TRUNC: begin
                if (push && push_eop) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath controls and registered status
    always_comb begin
        wr_en       = push && !full_q && (state_q != S_TRUNC) && !(push_eop && push_err);
        commit      = wr_en && push_eop;
        // Any eop that closes an errored, overflowed or already doomed packet throws it away.
        rewind      = push && push_eop && (push_err || full_q || (state_q == S_TRUNC));
        rd_en       = pop && !empty_q;
        eop_popped  = dout_vld_q && rd_word[0];

        wptr_d = wptr_q;
        if (rewind) begin
            wptr_d = cptr_q;
        end else if (wr_en) begin
            wptr_d = wptr_q + 1'b1;
        end

        cptr_d = cptr_q;
        if (commit) begin
            cptr_d = wptr_q + 1'b1;
        end

        rptr_d = rptr_q;
        if (rd_en) begin
            rptr_d = rptr_q + 1'b1;
        end

        pkt_cnt_d = pkt_cnt_q;
        case ({commit, eop_popped})
            2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
            2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
            default: pkt_cnt_d = pkt_cnt_q;
        endcase

        used_d      = wptr_d - rptr_d;
        full_d      = (used_d == PW'(DEPTH));
        empty_d     = (rptr_d == cptr_d);
        dout_vld_d  = rd_en;
        overflow_d  = push && full_q;
        underflow_d = pop && empty_q;
        drop_d      = rewind;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            cptr_q      <= '0;
            used_q      <= '0;
            pkt_cnt_q   <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            dout_vld_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cptr_q      <= cptr_d;
            used_q      <= used_d;
            pkt_cnt_q   <= pkt_cnt_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            dout_vld_q  <= dout_vld_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            drop_q      <= drop_d;
        end
    end

    ipbb_sfw_sdp_ram #(
        .W     (DW + 1),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_en),
        .waddr (wptr_q[AW-1:0]),
        .wdata ({din, push_eop}),
        .re    (rd_en),
        .raddr (rptr_q[AW-1:0]),
        .rdata (rd_word)
    );

`ifdef IPBB_SFW_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'h0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0;
`endif

    assign dout      = rd_word[DW:1];
    assign dout_eop  = rd_word[0];
    assign dout_vld  = dout_vld_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign used      = used_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_ipbb_sfw_pkt_fifo.sv
// tb/tb_ipbb_sfw_pkt_fifo.sv - scoreboard bench for the store-and-forward packet FIFO
module tb_ipbb_sfw_pkt_fifo;
    import ipbb_sfw_pkg::*;

`ifdef IPBB_SFW_DROP_CNT_EN
    localparam int CNT_EN = 1;
`else
    localparam int CNT_EN = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        push = 1'b0;
    logic [7:0]  din = 8'h0;
    logic        push_eop = 1'b0;
    logic        push_err = 1'b0;
    logic        pop;
    logic [7:0]  dout;
    logic        dout_eop;
    logic        dout_vld;
    logic        full;
    logic        empty;
    logic [4:0]  used;
    logic [4:0]  pkt_cnt;
    logic        overflow;
    logic        underflow;
    logic        drop;
    logic [15:0] drop_cnt;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [8:0] exp_q [$];

    int pop_req = 0;
    int pop_done = 0;
    bit rnd = 1'b0;
    int drop_seen = 0;
    int ov_seen = 0;
    bit pktcnt_bad = 1'b0;

    ipbb_sfw_pkt_fifo #(.DW(8), .DEPTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .din       (din),
        .push_eop  (push_eop),
        .push_err  (push_err),
        .pop       (pop),
        .dout      (dout),
        .dout_eop  (dout_eop),
        .dout_vld  (dout_vld),
        .full      (full),
        .empty     (empty),
        .used      (used),
        .pkt_cnt   (pkt_cnt),
        .overflow  (overflow),
        .underflow (underflow),
        .drop      (drop),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [7:0] base, input int len, input logic err, input bit rnd_data);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            d        = rnd_data ? 8'($urandom) : 8'(base + i);
            push     = 1'b1;
            din      = d;
            push_eop = (i == len - 1);
            push_err = err && (i == len - 1);
            if (!err) exp_q.push_back({d, (i == len - 1)});
            tick();
        end
        push     = 1'b0;
        push_eop = 1'b0;
        push_err = 1'b0;
    endtask

    // Pop driver: directed pop requests or a random pop stream.
    initial begin
        pop = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rnd) begin
                pop = ($urandom_range(0, 3) != 0);
            end else if (pop_done != pop_req) begin
                pop = 1'b1;
                pop_done++;
            end else begin
                pop = 1'b0;
            end
        end
    end

    // Monitor: every word the FIFO presents must be the next good-packet word.
    always @(negedge clk) begin
        if (dout_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dout", {23'h0, dout, dout_eop}, 32'hFFFF_FFFF);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("dout_word", {23'h0, dout, dout_eop}, {23'h0, e});
            end
        end
        if (drop) drop_seen++;
        if (overflow) ov_seen++;
        if (pkt_cnt > 5'd16) pktcnt_bad = 1'b1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int drops0;
        int ov0;
        int n_err;
        int wcyc;
        bit err;

        // Reset state
        repeat (3) tick();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_used", used, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_dout_vld", dout_vld, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Good 4-word packet
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; din = 8'(8'h10 + i); push_eop = (i == 3); push_err = 1'b0;
            exp_q.push_back({8'(8'h10 + i), (i == 3)});
            tick();
            if (i == 2) check("t1_empty_before_eop", empty, 1);
        end
        push = 1'b0; push_eop = 1'b0;
        check("t1_empty_after_eop", empty, 0);
        check("t1_pkt_cnt_1", pkt_cnt, 1);
        check("t1_used_4", used, 4);
        pop_req += 4;
        repeat (8) tick();
        check("t1_pkt_cnt_0", pkt_cnt, 0);
        check("t1_empty_end", empty, 1);
        check("t1_used_end", used, 0);

        // Errored packet is dropped
        push_pkt(8'h30, 3, 1'b1, 1'b0);
        check("t2_drop_pulse", drop, 1);
        check("t2_used", used, 0);
        check("t2_empty", empty, 1);
        check("t2_drop_cnt", drop_cnt, CNT_EN ? 1 : 0);
        tick();
        check("t2_drop_clear", drop, 0);

        // Overflow truncation behind a committed 10-word packet
        push_pkt(8'h20, 10, 1'b0, 1'b0);
        check("t3_used_10", used, 10);
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; din = 8'(8'h40 + i); push_eop = (i == 7); push_err = 1'b0;
            tick();
            if (i == 5) check("t3_no_ovf_yet", overflow, 0);
            if (i == 5) check("t3_full", full, 1);
            if (i == 6) check("t3_overflow", overflow, 1);
            if (i == 6) check("t3_state_trunc", 32'(dut.state_q), 32'(S_TRUNC));
            if (i == 7) check("t3_drop", drop, 1);
        end
        push = 1'b0; push_eop = 1'b0;
        check("t3_used_after", used, 10);
        check("t3_state_idle", 32'(dut.state_q), 32'(S_IDLE));
        pop_req += 10;
        repeat (14) tick();
        check("t3_drained", exp_q.size(), 0);
        check("t3_pkt_cnt", pkt_cnt, 0);
        check("t3_drop_cnt", drop_cnt, CNT_EN ? 2 : 0);

        // Underflow: 4 + 10 words have been read so far
        pop_req += 1;
        tick();
        check("t4_underflow", underflow, 1);
        check("t4_dout_vld", dout_vld, 0);
        check("t4_rptr_hold", dut.rptr_q, 14);
        tick();
        check("t4_underflow_clear", underflow, 0);

        // Reset mid-packet with one committed packet
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; din = 8'(8'h60 + i); push_eop = (i == 1); push_err = 1'b0;
            tick();
        end
        push = 1'b0; push_eop = 1'b0;
        check("t5_pkt_cnt_pre", pkt_cnt, 1);
        check("t5_used_pre", used, 4);
        #3;
        rst_n = 1'b0;
        #1;
        check("t5_rst_empty", empty, 1);
        check("t5_rst_used", used, 0);
        check("t5_rst_pkt_cnt", pkt_cnt, 0);
        check("t5_rst_drop", drop, 0);
        tick();
        rst_n = 1'b1;
        tick();
        push_pkt(8'h50, 3, 1'b0, 1'b0);
        pop_req += 3;
        repeat (7) tick();
        check("t5_post_rst_drained", exp_q.size(), 0);

        // Random packets with concurrent pops
        drops0 = drop_seen;
        ov0 = ov_seen;
        n_err = 0;
        rnd = 1'b1;
        for (int p = 0; p < 1000; p++) begin
            wcyc = 0;
            while (used > 5'd4 && wcyc < 200) begin
                tick();
                wcyc++;
            end
            if (wcyc >= 200) check("t6_flow_timeout", wcyc, 0);
            err = ($urandom_range(0, 7) == 0);
            if (err) n_err++;
            push_pkt(8'h0, $urandom_range(1, 12), err, 1'b1);
        end
        wcyc = 0;
        while (exp_q.size() != 0 && wcyc < 2000) begin
            tick();
            wcyc++;
        end
        rnd = 1'b0;
        repeat (4) tick();
        check("t6_drained", exp_q.size(), 0);
        check("t6_pkt_cnt", pkt_cnt, 0);
        check("t6_empty", empty, 1);
        check("t6_used", used, 0);
        check("t6_drops", drop_seen - drops0, n_err);
        check("t6_no_overflow", ov_seen - ov0, 0);
        check("t6_drop_cnt", drop_cnt, CNT_EN ? n_err : 0);
        check("t6_pkt_cnt_range", pktcnt_bad, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
